// File: rtl/ibex_pkg.sv
// Shared LSU response-stage types: access size encoding and response FSM states.
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10,
    LSU_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_FIRST = 2'b01,
    WAIT_LAST  = 2'b10
  } lsu_resp_state_e;

endpackage

// File: rtl/ibex_lsu_load_align.sv
// Combinational load-data alignment: shifts the {hi, lo} beat pair by the byte offset and extends.
module ibex_lsu_load_align
  import ibex_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  offset,
  input  lsu_size_e   size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [63:0] shifted_s;

  // Byte-shift the concatenated beats, then pick and extend the addressed lanes
  always_comb begin
    shifted_s = {hi, lo} >> {offset, 3'b000};
    case (size)
      LSU_HALF: data = {{16{sign & shifted_s[15]}}, shifted_s[15:0]};
      LSU_BYTE: data = {{24{sign & shifted_s[7]}}, shifted_s[7:0]};
      default:  data = shifted_s[31:0];
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_stage_chk.sv
// Protocol checks on the LSU response stage ports: no response while idle, no request while not ready.
module ibex_lsu_resp_stage_chk (
  input logic clk_i,
  input logic rst_i,
  input logic req_i,
  input logic ready_o,
  input logic data_rvalid_i,
  input logic busy_o
);

  logic busy_prev_q, orphan_q;

  // A reset that cut off an outstanding access may legitimately see that access's late beat
  always_ff @(posedge clk_i) begin
    busy_prev_q <= busy_o;
    if (rst_i) begin
      orphan_q <= busy_prev_q | orphan_q;
    end else if (data_rvalid_i | req_i) begin
      orphan_q <= 1'b0;
    end else begin
      orphan_q <= orphan_q;
    end
  end

  // Protocol assertions sampled on the active edge
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(data_rvalid_i && !busy_o && !orphan_q))
        else $error("lsu_resp_stage: response beat with no outstanding access");
      assert (!(req_i && !ready_o))
        else $error("lsu_resp_stage: descriptor offered while not ready");
    end
  end

endmodule

// File: rtl/ibex_lsu_resp_stage.sv
// LSU response stage: one completion per instruction from one or two bus beats.
// Optional IBEX_LSU_RESP_ERR_EARLY_EN: an error on the first beat of a split load completes at once.
module ibex_lsu_resp_stage
  import ibex_pkg::*;
#(
  parameter bit SplitBeats = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        req_split_i,
  output logic        ready_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        busy_o
);

  lsu_resp_state_e state_q, state_d;
  logic            we_q, sign_q, split_q, err_q;
  lsu_size_e       type_q;
  logic [1:0]      offset_q;
  logic [31:0]     beat0_q;

  logic            req_split_s, accept_s, last_done_s, early_done_s;
  logic [31:0]     align_hi_s, align_lo_s, align_data_s;

  assign req_split_s = SplitBeats & req_split_i;
  assign ready_o     = ~rst_i & ((state_q == IDLE) | ((state_q == WAIT_LAST) & data_rvalid_i));
  assign accept_s    = req_i & ready_o;

  // Next-state logic and completion qualifiers
  always_comb begin
    state_d      = state_q;
    last_done_s  = 1'b0;
    early_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = req_split_s ? WAIT_FIRST : WAIT_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_FIRST: begin
        if (data_rvalid_i) begin
`ifdef IBEX_LSU_RESP_ERR_EARLY_EN
          if (data_err_i & ~we_q) begin
            state_d      = IDLE;
            early_done_s = 1'b1;
          end else begin
            state_d = WAIT_LAST;
          end
`else
          state_d = WAIT_LAST;
`endif
        end else begin
          state_d = WAIT_FIRST;
        end
      end
      WAIT_LAST: begin
        if (data_rvalid_i) begin
          last_done_s = 1'b1;
          if (req_i) begin
            state_d = req_split_s ? WAIT_FIRST : WAIT_LAST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT_LAST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, descriptor, first-beat data and sticky error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      type_q   <= LSU_WORD;
      sign_q   <= 1'b0;
      offset_q <= 2'b00;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      beat0_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        we_q     <= req_we_i;
        type_q   <= lsu_size_e'(req_type_i);
        sign_q   <= req_sign_ext_i;
        offset_q <= req_offset_i;
        split_q  <= req_split_s;
        err_q    <= 1'b0;
      end else if ((state_q == WAIT_FIRST) && data_rvalid_i) begin
        beat0_q <= data_rdata_i;
        err_q   <= data_err_i;
      end
    end
  end

  // Split accesses take the low word from the captured first beat
  assign align_hi_s = split_q ? data_rdata_i : 32'h0000_0000;
  assign align_lo_s = split_q ? beat0_q : data_rdata_i;

  ibex_lsu_load_align u_load_align (
    .hi     (align_hi_s),
    .lo     (align_lo_s),
    .offset (offset_q),
    .size   (type_q),
    .sign   (sign_q),
    .data   (align_data_s)
  );

  assign lsu_resp_valid_o = ~rst_i & (last_done_s | early_done_s);
  assign lsu_resp_err_o   = lsu_resp_valid_o & (err_q | data_err_i);
  assign rf_we_lsu_o      = lsu_resp_valid_o & ~we_q & ~lsu_resp_err_o;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? align_data_s : 32'h0000_0000;
  assign busy_o           = ~rst_i & (state_q != IDLE);

endmodule

// File: tb/tb_ibex_lsu_resp_stage.sv
// Scoreboard bench for ibex_lsu_resp_stage: directed descriptors push expectations, a monitor checks completions.
module tb_ibex_lsu_resp_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, req_we_i, req_sign_ext_i, req_split_i;
  logic [1:0]  req_type_i, req_offset_i;
  logic        ready_o;
  logic        data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic [31:0] rf_wdata_lsu_o;
  logic        rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, busy_o;

  typedef struct packed {
    logic        err;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ibex_lsu_resp_stage #(.SplitBeats(1'b1)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .req_we_i         (req_we_i),
    .req_type_i       (req_type_i),
    .req_sign_ext_i   (req_sign_ext_i),
    .req_offset_i     (req_offset_i),
    .req_split_i      (req_split_i),
    .ready_o          (ready_o),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .data_err_i       (data_err_i),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_err_o   (lsu_resp_err_o),
    .busy_o           (busy_o)
  );

  ibex_lsu_resp_stage_chk u_chk (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .ready_o       (ready_o),
    .data_rvalid_i (data_rvalid_i),
    .busy_o        (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected completion: write-enable only for an error-free load, data zero otherwise
  task automatic push_exp(input logic we, input logic err, input logic [31:0] wdata);
    exp_t e;
    e.err   = err;
    e.we    = ~we & ~err;
    e.wdata = e.we ? wdata : 32'h0000_0000;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input logic we, input logic [1:0] ty, input logic sx,
                         input logic [1:0] off, input logic sp);
    req_i          = 1'b1;
    req_we_i       = we;
    req_type_i     = ty;
    req_sign_ext_i = sx;
    req_offset_i   = off;
    req_split_i    = sp;
  endtask

  task automatic issue(input logic we, input logic [1:0] ty, input logic sx,
                       input logic [1:0] off, input logic sp);
    set_req(we, ty, sx, off, sp);
    tick();
    req_i = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic e, input logic last, input string nm);
    data_rvalid_i = 1'b1;
    data_rdata_i  = d;
    data_err_i    = e;
    #1;
    check(nm, {63'd0, lsu_resp_valid_o}, {63'd0, last});
    @(posedge clk);
    #1;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
  endtask

  // Monitor: every completion pops one expectation; idle cycles must show no write
  always @(negedge clk) begin
    if (lsu_resp_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: valid=1 err=%0b we=%0b wdata=%h, expected none",
                 lsu_resp_err_o, rf_we_lsu_o, rf_wdata_lsu_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp", {30'd0, lsu_resp_err_o, rf_we_lsu_o, rf_wdata_lsu_o},
              {30'd0, e.err, e.we, e.wdata});
      end
    end else begin
      check("idle_quiet", {31'd0, rf_we_lsu_o, rf_wdata_lsu_o}, 64'd0);
    end
  end

  initial begin
    rst_i = 1'b1;
    req_i = 1'b0; req_we_i = 1'b0; req_type_i = 2'b00; req_sign_ext_i = 1'b0;
    req_offset_i = 2'b00; req_split_i = 1'b0;
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0000_0000; data_err_i = 1'b0;

    repeat (3) tick();
    check("reset_outs", {60'd0, ready_o, busy_o, lsu_resp_valid_o, lsu_resp_err_o}, 64'd0);
    rst_i = 1'b0;
    #1;
    check("post_reset_ready", {62'd0, ready_o, busy_o}, 64'd2);

    // Aligned word load
    push_exp(1'b0, 1'b0, 32'hDEAD_BEEF);
    issue(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
    check("busy_outstanding", {63'd0, busy_o}, 64'd1);
    beat(32'hDEAD_BEEF, 1'b0, 1'b1, "word_last");

    // Byte loads at offset 3, signed then unsigned
    push_exp(1'b0, 1'b0, 32'hFFFF_FF80);
    issue(1'b0, 2'b10, 1'b1, 2'd3, 1'b0);
    beat(32'h80FF_0000, 1'b0, 1'b1, "sbyte_last");
    push_exp(1'b0, 1'b0, 32'h0000_0080);
    issue(1'b0, 2'b10, 1'b0, 2'd3, 1'b0);
    beat(32'h80FF_0000, 1'b0, 1'b1, "ubyte_last");

    // Half loads: signed at offset 2, unsigned at offset 0
    push_exp(1'b0, 1'b0, 32'hFFFF_8001);
    issue(1'b0, 2'b01, 1'b1, 2'd2, 1'b0);
    beat(32'h8001_1234, 1'b0, 1'b1, "shalf_last");
    push_exp(1'b0, 1'b0, 32'h0000_8001);
    issue(1'b0, 2'b01, 1'b0, 2'd0, 1'b0);
    beat(32'hFFFF_8001, 1'b0, 1'b1, "uhalf_last");

    // Split word at offset 2
    push_exp(1'b0, 1'b0, 32'h1111_BBBB);
    issue(1'b0, 2'b00, 1'b0, 2'd2, 1'b1);
    beat(32'hBBBB_AAAA, 1'b0, 1'b0, "splitw_beat1");
    beat(32'h2222_1111, 1'b0, 1'b1, "splitw_beat2");

    // Split signed half at offset 3, no error
    push_exp(1'b0, 1'b0, 32'hFFFF_8811);
    issue(1'b0, 2'b01, 1'b1, 2'd3, 1'b1);
    beat(32'h1122_3344, 1'b0, 1'b0, "splith_beat1");
    beat(32'h5566_7788, 1'b0, 1'b1, "splith_beat2");

    // Split half at offset 3 with an error on the first beat
    push_exp(1'b0, 1'b1, 32'h0000_0000);
    issue(1'b0, 2'b01, 1'b0, 2'd3, 1'b1);
`ifdef IBEX_LSU_RESP_ERR_EARLY_EN
    beat(32'h1234_5678, 1'b1, 1'b1, "spliterr_beat1");
`else
    beat(32'h1234_5678, 1'b1, 1'b0, "spliterr_beat1");
    beat(32'h9ABC_DEF0, 1'b0, 1'b1, "spliterr_beat2");
`endif

    // Store without error
    push_exp(1'b1, 1'b0, 32'h0000_0000);
    issue(1'b1, 2'b00, 1'b0, 2'd0, 1'b0);
    beat(32'h5555_5555, 1'b0, 1'b1, "store_last");

    // Erroring store completes while the next load is accepted in the same cycle
    push_exp(1'b1, 1'b1, 32'h0000_0000);
    issue(1'b1, 2'b00, 1'b0, 2'd0, 1'b0);
    push_exp(1'b0, 1'b0, 32'h0000_00AB);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h0000_0000;
    data_err_i    = 1'b1;
    set_req(1'b0, 2'b10, 1'b0, 2'd1, 1'b0);
    #1;
    check("b2b_ready_valid", {62'd0, ready_o, lsu_resp_valid_o}, 64'd3);
    tick();
    req_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    check("b2b_busy", {63'd0, busy_o}, 64'd1);
    beat(32'h0000_AB00, 1'b0, 1'b1, "b2b_load_last");

    // Reset between the two beats of a split load discards it
    issue(1'b0, 2'b00, 1'b0, 2'd1, 1'b1);
    beat(32'hCAFE_F00D, 1'b0, 1'b0, "rst_beat1");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    beat(32'h0BAD_0BAD, 1'b0, 1'b0, "rst_beat2_dropped");
    check("rst_idle", {62'd0, busy_o, rf_we_lsu_o}, 64'd0);

    push_exp(1'b0, 1'b0, 32'h1234_5678);
    issue(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
    beat(32'h1234_5678, 1'b0, 1'b1, "post_rst_last");

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
